// File: rtl/bp_pkg.sv
// Shared types for the branch prediction tracker: FIFO entry layout and tracker FSM states.
package bp_pkg;
  localparam int BP_PC_W = 32;

  typedef struct packed {
    logic [BP_PC_W-1:0] pc;
    logic               pred;
  } bp_entry_t;

  typedef enum logic {RUN = 1'b0, RECOVER = 1'b1} tracker_state_t;
endpackage

// File: rtl/branch_pred_tracker_if.sv
// Pipeline-side bus of the tracker: IF/ID inputs, predictor update, flush and statistics outputs.
interface branch_pred_tracker_if #(parameter int PC_W = 32, parameter int CNT_W = 16);
  logic            IF_Valid;
  logic [PC_W-1:0] IF_PC;
  logic            IF_Pred;
  logic            ID_Valid;
  logic [PC_W-1:0] ID_PC;
  logic            ID_Is_Branch;
  logic            ID_Is_Taken;
  logic [PC_W-1:0] ID_Target;
  logic             Upd_Branch;
  logic             Upd_Taken;
  logic [PC_W-1:0]  Upd_PC;
  logic             Flush;
  logic [PC_W-1:0]  Redirect_PC;
  logic             IF_Stall;
  logic             Sync_Err;
  logic [CNT_W-1:0] Br_Count;
  logic [CNT_W-1:0] Mis_Count;

  modport master (
    output IF_Valid, IF_PC, IF_Pred, ID_Valid, ID_PC, ID_Is_Branch, ID_Is_Taken, ID_Target,
    input  Upd_Branch, Upd_Taken, Upd_PC, Flush, Redirect_PC, IF_Stall, Sync_Err, Br_Count, Mis_Count
  );
  modport slave (
    input  IF_Valid, IF_PC, IF_Pred, ID_Valid, ID_PC, ID_Is_Branch, ID_Is_Taken, ID_Target,
    output Upd_Branch, Upd_Taken, Upd_PC, Flush, Redirect_PC, IF_Stall, Sync_Err, Br_Count, Mis_Count
  );
endinterface

// File: rtl/bp_fifo.sv
// In-order FIFO of IF-stage predictions; clear wins over push/pop, pop on empty is a no-op.
module bp_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      CLK,
  input  logic      RESET,
  input  logic      push,
  input  logic      pop,
  input  logic      clear,
  input  bp_entry_t din,
  output bp_entry_t head,
  output logic      full,
  output logic      empty
);
  localparam int AW = $clog2(DEPTH);

  bp_entry_t     mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          do_pop, do_push;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rp];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (clear) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push && !clear) mem[wp] <= din;
  end
endmodule

// File: rtl/branch_pred_tracker.sv
// Pairs IF predictions with ID resolutions, updates the predictor, flushes on mispredict, counts accuracy.
module branch_pred_tracker
  import bp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = BP_PC_W,
  parameter int CNT_W = 16
) (
  input logic CLK,
  input logic RESET,
  branch_pred_tracker_if.slave bus
);
  tracker_state_t   state;
  bp_entry_t        head, din;
  logic             full, empty, pop, push, match, pred, mispred;
  logic             upd_branch, upd_taken, flush, sync_err;
  logic [PC_W-1:0]  upd_pc, redirect_pc;
  logic [CNT_W-1:0] br_cnt, mis_cnt;

  assign din     = '{pc: bus.IF_PC, pred: bus.IF_Pred};
  // ID retirements during RECOVER belong to the squashed path and are not popped
  assign pop     = bus.ID_Valid && (state == RUN);
  assign push    = bus.IF_Valid && (state == RUN);
  assign match   = !empty && (head.pc == bus.ID_PC);
  assign pred    = match && head.pred;
  assign mispred = pop && bus.ID_Is_Branch && (pred != bus.ID_Is_Taken);

  bp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK  (CLK),
    .RESET(RESET),
    .push (push),
    .pop  (pop),
    .clear(mispred),
    .din  (din),
    .head (head),
    .full (full),
    .empty(empty)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= RUN;
      upd_branch  <= 1'b0;
      upd_taken   <= 1'b0;
      upd_pc      <= '0;
      flush       <= 1'b0;
      redirect_pc <= '0;
      sync_err    <= 1'b0;
      br_cnt      <= '0;
      mis_cnt     <= '0;
    end else begin
      state       <= mispred ? RECOVER : RUN;
      upd_branch  <= bus.ID_Valid && bus.ID_Is_Branch;
      upd_taken   <= bus.ID_Is_Taken;
      upd_pc      <= bus.ID_PC;
      flush       <= mispred;
      redirect_pc <= !mispred ? '0 : bus.ID_Is_Taken ? bus.ID_Target : bus.ID_PC + PC_W'(4);
      sync_err    <= pop && !match;
      if (bus.ID_Valid && bus.ID_Is_Branch && br_cnt != '1) br_cnt <= br_cnt + CNT_W'(1);
      if (mispred && mis_cnt != '1) mis_cnt <= mis_cnt + CNT_W'(1);
    end
  end

  assign bus.IF_Stall    = full || (state == RECOVER);
  assign bus.Upd_Branch  = upd_branch;
  assign bus.Upd_Taken   = upd_taken;
  assign bus.Upd_PC      = upd_pc;
  assign bus.Flush       = flush;
  assign bus.Redirect_PC = redirect_pc;
  assign bus.Sync_Err    = sync_err;
  assign bus.Br_Count    = br_cnt;
  assign bus.Mis_Count   = mis_cnt;
endmodule

// File: tb/tb_branch_pred_tracker.sv
// Directed scenarios plus random traffic checked against a queue-based model of the tracker.
module tb_branch_pred_tracker;
  localparam int DEPTH = 4, PC_W = 32, CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic CLK = 1'b0, RESET = 1'b0;
  always #5 CLK = ~CLK;

  branch_pred_tracker_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();
  branch_pred_tracker #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus.slave));

  typedef struct { logic [31:0] pc; bit pred; } ent_t;
  ent_t        q[$];
  bit          rec, e_ub, e_ut, e_fl, e_se;
  logic [31:0] e_upc, e_rd;
  int          e_bc, e_mc;
  int          n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs(input string pfx);
    chk({pfx, "_upd_branch"}, bus.Upd_Branch, e_ub);
    chk({pfx, "_upd_taken"},  bus.Upd_Taken,  e_ut);
    chk({pfx, "_upd_pc"},     bus.Upd_PC,     e_upc);
    chk({pfx, "_flush"},      bus.Flush,      e_fl);
    chk({pfx, "_redirect"},   bus.Redirect_PC, e_rd);
    chk({pfx, "_sync_err"},   bus.Sync_Err,   e_se);
    chk({pfx, "_br_cnt"},     bus.Br_Count,   e_bc);
    chk({pfx, "_mis_cnt"},    bus.Mis_Count,  e_mc);
  endtask

  task automatic model_clear();
    q.delete();
    rec = 0; e_ub = 0; e_ut = 0; e_fl = 0; e_se = 0; e_upc = 0; e_rd = 0; e_bc = 0; e_mc = 0;
  endtask

  task automatic drive_idle();
    bus.IF_Valid = 0; bus.IF_PC = 0; bus.IF_Pred = 0; bus.ID_Valid = 0; bus.ID_PC = 0;
    bus.ID_Is_Branch = 0; bus.ID_Is_Taken = 0; bus.ID_Target = 0;
  endtask

  // One clock: drive, check stall, advance the model, then check registered outputs.
  task automatic step(input bit ifv, input logic [31:0] ifpc, input bit ifp,
                      input bit idv, input logic [31:0] idpc, input bit br, input bit tk,
                      input logic [31:0] tgt);
    bit pop, match, pred, mis, push;
    bus.IF_Valid = ifv; bus.IF_PC = ifpc; bus.IF_Pred = ifp; bus.ID_Valid = idv; bus.ID_PC = idpc;
    bus.ID_Is_Branch = br; bus.ID_Is_Taken = tk; bus.ID_Target = tgt;
    #1;
    chk("if_stall", bus.IF_Stall, (q.size() == DEPTH) || rec);
    pop   = idv && !rec;
    match = q.size() > 0 && q[0].pc == idpc;
    pred  = match && q[0].pred;
    mis   = pop && br && (pred != tk);
    push  = ifv && !rec && (q.size() < DEPTH || pop);
    if (pop && q.size() > 0) void'(q.pop_front());
    if (push) q.push_back('{pc: ifpc, pred: ifp});
    if (mis) q.delete();
    e_ub = idv && br; e_ut = tk; e_upc = idpc; e_fl = mis; e_se = pop && !match;
    e_rd = mis ? (tk ? tgt : idpc + 32'd4) : 32'd0;
    if (idv && br && e_bc < CMAX) e_bc++;
    if (mis && e_mc < CMAX) e_mc++;
    rec = mis;
    @(posedge CLK); #1;
    check_outs("cyc");
  endtask

  task automatic idle(); step(0, 0, 0, 0, 0, 0, 0, 0); endtask

  // Asynchronous reset away from any edge; outputs must clear before the next clock.
  task automatic do_reset();
    RESET = 0;
    drive_idle();
    #2;
    model_clear();
    check_outs("rst");
    chk("rst_if_stall", bus.IF_Stall, 0);
    @(negedge CLK) RESET = 1;
    @(posedge CLK); #1;
  endtask

  initial begin
    model_clear();
    drive_idle();
    #12;
    check_outs("init");
    chk("init_if_stall", bus.IF_Stall, 0);
    @(negedge CLK) RESET = 1;
    @(posedge CLK); #1;

    // correct taken prediction
    step(1, 32'h100, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h100, 1, 1, 32'h180);
    chk("t1_upd_pc", bus.Upd_PC, 32'h100);
    chk("t1_br_cnt", bus.Br_Count, 1);

    // predicted not-taken, resolved taken -> flush to target
    step(1, 32'h200, 0, 0, 0, 0, 0, 0);
    step(1, 32'h204, 1, 0, 0, 0, 0, 0);
    step(1, 32'h208, 1, 1, 32'h200, 1, 1, 32'h300);
    chk("t2_flush", bus.Flush, 1);
    chk("t2_redirect", bus.Redirect_PC, 32'h300);
    chk("t2_stall", bus.IF_Stall, 1);
    step(1, 32'h300, 0, 0, 0, 0, 0, 0);   // dropped during RECOVER
    chk("t2_stall_off", bus.IF_Stall, 0);

    // predicted taken, resolved not-taken -> fall-through, including PC wrap
    step(1, 32'h400, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h400, 1, 0, 32'h500);
    chk("t3_redirect", bus.Redirect_PC, 32'h404);
    idle();
    step(1, 32'hFFFF_FFFC, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'hFFFF_FFFC, 1, 0, 32'h10);
    chk("t3_wrap", bus.Redirect_PC, 32'h0);
    idle();

    // fill, drop while full, then push+pop while full
    for (int i = 0; i < DEPTH; i++) step(1, 32'h500 + 4 * i, 0, 0, 0, 0, 0, 0);
    chk("t4_full_stall", bus.IF_Stall, 1);
    step(1, 32'h5F0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h600, 0, 1, 32'h500, 0, 0, 0);
    chk("t4_still_full", bus.IF_Stall, 1);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, q.size() > 0 ? q[0].pc : 32'h0, 0, 0, 0);

    // pop on empty, then pop with PC mismatch
    step(0, 0, 0, 1, 32'h700, 1, 1, 32'h740);
    chk("t5_sync_err", bus.Sync_Err, 1);
    chk("t5_flush", bus.Flush, 1);
    idle();
    step(1, 32'h800, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h804, 0, 0, 0);
    chk("t5_mismatch", bus.Sync_Err, 1);
    idle();

    // empty + push + pop in the same cycle: no bypass
    step(1, 32'h900, 1, 1, 32'h900, 0, 0, 0);
    idle();

    // mispredict saturation
    for (int i = 0; i < CMAX + 2; i++) begin
      step(0, 0, 0, 1, 32'hA00, 1, 1, 32'hB00);
      idle();
    end
    chk("t6_mis_sat", bus.Mis_Count, CMAX);

    // random traffic with a reset in the middle
    for (int i = 0; i < 800; i++) begin
      bit idv;
      logic [31:0] idpc;
      if (i == 400) begin
        step(1, 32'hC00, 1, 0, 0, 0, 0, 0);
        #2; do_reset();
      end
      idv  = !rec && ($urandom_range(0, 2) != 0);
      idpc = (q.size() > 0 && $urandom_range(0, 7) != 0) ? q[0].pc : ($urandom & 32'hFFFF_FFFC);
      step($urandom_range(0, 1), $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1),
           idv, idpc, $urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom & 32'hFFFF_FFFC);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
